// File: rtl/udp_loopback_buffer.sv
// Ping-pong payload buffer between the UDP RX and TX engines.
// RX fills the write bank while TX reads the other; banks swap only at frame boundaries.
// A built-in default message is served until the first frame arrives, or when mode forces it.
module udp_loopback_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DEF_WORDS = 5,
  // "HELLO ALINX AX530 \n\r", word 0 in the most significant bits
  parameter logic [DEF_WORDS*DATA_W-1:0] DEF_MSG =
    160'h48454C4C_4F20414C_494E5820_41583533_30200A0D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode,
  input  logic              rx_valid,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic [15:0]       rx_data_length,
  input  logic              tx_start,
  input  logic              tx_end,
  input  logic [ADDR_W-1:0] tx_rd_addr,
  output logic [DATA_W-1:0] tx_rd_data,
  output logic [15:0]       tx_data_length,
  output logic [15:0]       tx_total_length,
  output logic              have_rx,
  output logic [7:0]        drop_cnt,
  output logic              rd_bank
);

  localparam int unsigned Depth   = 2 ** (ADDR_W + 1);
  localparam logic [15:0] DefLen  = 16'(DEF_WORDS * DATA_W / 8 + 8);

  typedef enum logic [1:0] {StIdle, StBusy, StPend} state_e;

  state_e state_q, state_d;

  // Both banks share one array; the bank bit is the address MSB.
  logic [DATA_W-1:0] mem [Depth];

  logic [15:0]       len_rx [2];
  logic [15:0]       pend_len;
  logic              src_q;
  logic              src_in;
  logic              src_eff;
  logic              do_swap;
  logic              swap_from_pend;
  logic              latch_pend;
  logic              drop;
  logic              wr_en;
  logic              len_upd;
  logic [15:0]       swap_len;
  logic [15:0]       len_sel;
  logic [DATA_W-1:0] def_word;

  assign src_in   = mode | ~have_rx;
  // While idle the source follows its input; inside a TX frame it is held.
  assign src_eff  = (state_q == StIdle) ? src_in : src_q;
  assign wr_en    = rx_valid && (state_q != StPend);
  assign swap_len = swap_from_pend ? pend_len : rx_data_length;
  // Lengths are frozen from tx_start through tx_end.
  assign len_upd  = (state_q == StIdle) && !tx_start;
  assign len_sel  = src_eff ? DefLen : len_rx[rd_bank];

  // Next-state and swap/drop decisions.
  always_comb begin
    state_d        = state_q;
    do_swap        = 1'b0;
    swap_from_pend = 1'b0;
    latch_pend     = 1'b0;
    drop           = 1'b0;
    case (state_q)
      StIdle: begin
        if (tx_start) begin
          // A frame completing as TX starts must wait for tx_end.
          latch_pend = rx_done;
          state_d    = rx_done ? StPend : StBusy;
        end else if (rx_done) begin
          do_swap = 1'b1;
        end
      end
      StBusy: begin
        if (tx_end) begin
          do_swap = rx_done;
          state_d = StIdle;
        end else if (rx_done) begin
          latch_pend = 1'b1;
          state_d    = StPend;
        end
      end
      StPend: begin
        drop = rx_done;
        if (tx_end) begin
          do_swap        = 1'b1;
          swap_from_pend = 1'b1;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Default-message ROM lookup; out-of-range addresses read as zero.
  always_comb begin
    def_word = '0;
    for (int i = 0; i < DEF_WORDS; i++) begin
      if (tx_rd_addr == ADDR_W'(i)) def_word = DEF_MSG[(DEF_WORDS-1-i)*DATA_W +: DATA_W];
    end
  end

  // Control state: FSM, bank select, lengths, drop counter, source latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rd_bank   <= 1'b0;
      have_rx   <= 1'b0;
      drop_cnt  <= 8'd0;
      pend_len  <= DefLen;
      len_rx[0] <= DefLen;
      len_rx[1] <= DefLen;
      src_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) src_q <= src_in;
      if (latch_pend) pend_len <= rx_data_length;
      if (do_swap) begin
        rd_bank          <= ~rd_bank;
        len_rx[~rd_bank] <= swap_len;
        have_rx          <= 1'b1;
      end
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Payload RAM write into the bank not presented to TX.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~rd_bank, rx_addr}] <= rx_data;
  end

  // Registered read data, one cycle after the address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_rd_data <= '0;
    end else begin
      tx_rd_data <= src_eff ? def_word : mem[{rd_bank, tx_rd_addr}];
    end
  end

  // Registered UDP and IP length fields.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_data_length  <= DefLen;
      tx_total_length <= DefLen + 16'd20;
    end else if (len_upd) begin
      tx_data_length  <= len_sel;
      tx_total_length <= len_sel + 16'd20;
    end
  end

endmodule

// File: tb/tb_udp_loopback_buffer.sv
// Directed bench for udp_loopback_buffer with a read-data scoreboard.
module tb_udp_loopback_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode;
  logic        rx_valid;
  logic [8:0]  rx_addr;
  logic [31:0] rx_data;
  logic        rx_done;
  logic [15:0] rx_data_length;
  logic        tx_start;
  logic        tx_end;
  logic [8:0]  tx_rd_addr;
  logic [31:0] tx_rd_data;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        have_rx;
  logic [7:0]  drop_cnt;
  logic        rd_bank;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] def_w [6];
  logic [31:0] a_w [3];
  logic [31:0] b_w [3];
  logic [31:0] c_w [3];

  udp_loopback_buffer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mode            (mode),
    .rx_valid        (rx_valid),
    .rx_addr         (rx_addr),
    .rx_data         (rx_data),
    .rx_done         (rx_done),
    .rx_data_length  (rx_data_length),
    .tx_start        (tx_start),
    .tx_end          (tx_end),
    .tx_rd_addr      (tx_rd_addr),
    .tx_rd_data      (tx_rd_data),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .have_rx         (have_rx),
    .drop_cnt        (drop_cnt),
    .rd_bank         (rd_bank)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_len(input string tag, input logic [15:0] exp);
    chk({tag, "_udp"}, 32'(tx_data_length), 32'(exp));
    chk({tag, "_ip"}, 32'(tx_total_length), 32'(exp + 16'd20));
  endtask

  // Present an address, queue the expected word, compare when it emerges.
  task automatic rd(input string tag, input logic [8:0] a, input logic [31:0] exp);
    tx_rd_addr = a;
    sb_q.push_back(exp);
    step();
    chk(tag, tx_rd_data, sb_q.pop_front());
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    rx_valid = 1'b1;
    rx_addr  = a;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic done(input logic [15:0] len);
    rx_done        = 1'b1;
    rx_data_length = len;
    step();
    rx_done = 1'b0;
  endtask

  task automatic start_tx();
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic end_tx();
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
  endtask

  initial begin
    def_w = '{32'h48454C4C, 32'h4F20414C, 32'h494E5820, 32'h41583533, 32'h30200A0D, 32'h0};
    a_w   = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2};
    b_w   = '{32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2};
    c_w   = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2};
    reset_n = 1'b0; mode = 1'b0; rx_valid = 1'b0; rx_addr = '0; rx_data = '0;
    rx_done = 1'b0; rx_data_length = '0; tx_start = 1'b0; tx_end = 1'b0; tx_rd_addr = '0;

    // Reset values
    step(); step();
    chk("rst_rd_data", tx_rd_data, 32'h0);
    chk("rst_bank", 32'(rd_bank), 32'd0);
    chk("rst_have_rx", 32'(have_rx), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk_len("rst_len", 16'd28);
    reset_n = 1'b1;
    step();

    // Default message
    start_tx();
    for (int i = 0; i < 6; i++) rd("def_rd", 9'(i), def_w[i]);
    chk_len("def_len", 16'd28);
    end_tx();

    // Echo
    wr(9'd0, 32'h11111111); wr(9'd1, 32'h22222222); wr(9'd2, 32'h33333333);
    done(16'd20);
    chk("echo_bank", 32'(rd_bank), 32'd1);
    chk("echo_have_rx", 32'(have_rx), 32'd1);
    step();
    chk_len("echo_len", 16'd20);
    start_tx();
    rd("echo_rd0", 9'd0, 32'h11111111);
    rd("echo_rd1", 9'd1, 32'h22222222);
    rd("echo_rd2", 9'd2, 32'h33333333);

    // Deferred swap: frame completes during TX
    for (int i = 0; i < 3; i++) wr(9'(i), a_w[i]);
    done(16'd24);
    rd("pend_old_rd", 9'd0, 32'h11111111);
    chk("pend_bank", 32'(rd_bank), 32'd1);
    chk_len("pend_len_frozen", 16'd20);
    end_tx();
    chk("defer_bank", 32'(rd_bank), 32'd0);
    chk_len("defer_len_lag", 16'd20);
    step();
    chk_len("defer_len", 16'd24);
    for (int i = 0; i < 3; i++) rd("defer_rd", 9'(i), a_w[i]);

    // Drops: writes blocked while pending, drop with tx_end counted
    start_tx();
    for (int i = 0; i < 3; i++) wr(9'(i), b_w[i]);
    done(16'd32);
    wr(9'd0, 32'hDEADBEEF);
    done(16'd99);
    chk("drop_one", 32'(drop_cnt), 32'd1);
    rx_done = 1'b1; rx_data_length = 16'd77; tx_end = 1'b1;
    step();
    rx_done = 1'b0; tx_end = 1'b0;
    chk("drop_two", 32'(drop_cnt), 32'd2);
    chk("drop_bank", 32'(rd_bank), 32'd1);
    step();
    chk_len("drop_len", 16'd32);
    for (int i = 0; i < 3; i++) rd("drop_rd", 9'(i), b_w[i]);
    start_tx();
    done(16'd12);
    for (int i = 0; i < 300; i++) done(16'd5);
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    end_tx();
    step();
    chk("sat_bank", 32'(rd_bank), 32'd0);
    chk_len("sat_len", 16'd12);

    // Mode forcing the default message
    mode = 1'b1;
    step(); step();
    chk_len("mode_len", 16'd28);
    rd("mode_rd", 9'd0, def_w[0]);
    mode = 1'b0;
    step(); step();
    chk_len("unmode_len", 16'd12);
    start_tx();
    mode = 1'b1;
    step();
    rd("midtx_rd", 9'd0, a_w[0]);
    chk_len("midtx_len", 16'd12);
    end_tx();
    step();
    chk_len("post_tx_len", 16'd28);
    rd("post_tx_rd", 9'd4, def_w[4]);
    mode = 1'b0;
    step(); step();

    // tx_end and rx_done together while busy
    start_tx();
    for (int i = 0; i < 3; i++) wr(9'(i), c_w[i]);
    rx_done = 1'b1; rx_data_length = 16'd40; tx_end = 1'b1;
    step();
    rx_done = 1'b0; tx_end = 1'b0;
    chk("simul_end_bank", 32'(rd_bank), 32'd1);
    step();
    chk_len("simul_end_len", 16'd40);
    rd("simul_end_rd", 9'd1, c_w[1]);

    // tx_start and rx_done together while idle
    wr(9'd0, 32'hD0D0D0D0);
    rx_done = 1'b1; rx_data_length = 16'd16; tx_start = 1'b1;
    step();
    rx_done = 1'b0; tx_start = 1'b0;
    chk("simul_start_bank", 32'(rd_bank), 32'd1);
    rd("simul_start_rd", 9'd0, c_w[0]);
    chk_len("simul_start_len", 16'd40);
    wr(9'd0, 32'hEEEEEEEE);
    end_tx();
    chk("simul_start_swap", 32'(rd_bank), 32'd0);
    step();
    chk_len("simul_start_len2", 16'd16);
    rd("simul_start_rd2", 9'd0, 32'hD0D0D0D0);

    // Reset while pending
    rx_done = 1'b1; rx_data_length = 16'd50; tx_start = 1'b1;
    step();
    rx_done = 1'b0; tx_start = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("prst_bank", 32'(rd_bank), 32'd0);
    chk("prst_have_rx", 32'(have_rx), 32'd0);
    chk("prst_drop", 32'(drop_cnt), 32'd0);
    chk_len("prst_len", 16'd28);
    rd("prst_rd", 9'd1, def_w[1]);
    // Idle after reset: a lone rx_done swaps rather than counting a drop
    done(16'd36);
    chk("prst_idle_bank", 32'(rd_bank), 32'd1);
    chk("prst_idle_drop", 32'(drop_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/udp_loopback_buffer.md
# udp_loopback_buffer

Parametrised ping-pong payload buffer between the UDP receive and transmit engines of the Ethernet test design. Received UDP payload words are written into one bank while the transmitter reads the other. Banks swap only at frame boundaries, so a frame being transmitted is never corrupted. A built-in default message (register ROM) is served until the first frame arrives, or always when `mode` forces it; the block also supplies the matching UDP and IP length fields to the transmitter.

## Interface
Parameters:
- `DATA_W`, 32: payload word width, in bits.
- `ADDR_W`, 9: word address width; each bank holds 2^ADDR_W words.
- `DEF_WORDS`, 5: number of words in the default message.
- `DEF_MSG`, "HELLO ALINX AX530\n\r" packed, DEF_WORDS*DATA_W bits: default payload; word 0 occupies the most significant DATA_W bits.

Ports:
- `clk` in 1: single clock, GMII rx clock domain; all logic on the rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `mode` in 1: 0 = echo the last received frame; 1 = always send `DEF_MSG`.
- `rx_valid` in 1: payload word write strobe from the UDP RX engine.
- `rx_addr` in ADDR_W: word address within the frame.
- `rx_data` in DATA_W: payload word.
- `rx_done` in 1: one-cycle pulse marking that a complete frame is in the write bank.
- `rx_data_length` in 16: UDP length (payload + 8), sampled on `rx_done`.
- `tx_start` in 1: pulse; TX begins reading a frame.
- `tx_end` in 1: pulse; TX has finished reading.
- `tx_rd_addr` in ADDR_W: TX read word address.
- `tx_rd_data` out DATA_W: read data.
- `tx_data_length` out 16: UDP length for TX.
- `tx_total_length` out 16: IP total length, equal to `tx_data_length` + 20.
- `have_rx` out 1: at least one frame has been accepted since reset.
- `drop_cnt` out 8: count of dropped frames; saturates at 255.
- `rd_bank` out 1: bank currently presented to TX (for debug).

## Operation
- Storage: two banks of 2^ADDR_W × DATA_W, inferred RAM, contents not reset.
- Writes go to bank `~rd_bank` at `rx_addr` when `rx_valid` is high and writes are not blocked.
- Per-frame lengths are held in `len_rx[bank]`. The default length is DEF_WORDS×DATA_W/8 + 8, which is 28 at the default parameters.
- Source select `src_def = mode | ~have_rx` is latched on `tx_start`. Outside a TX frame the latched value tracks its input every cycle.
- `tx_rd_data` comes from `DEF_MSG` word `tx_rd_addr` when `src_def` is set, otherwise from bank `rd_bank`.
- A default read with `tx_rd_addr` ≥ DEF_WORDS returns 0.
- Swap action: `rd_bank <= ~rd_bank`, `len_rx[rd]` takes the sampled length, `have_rx <= 1`.
- State machine:
  - S_IDLE:
    - `tx_start` → S_BUSY.
    - `rx_done` alone → swap, stay in S_IDLE.
    - `tx_start` and `rx_done` in the same cycle → latch the length into the pending register, go to S_PEND. TX reads the old bank.
  - S_BUSY:
    - `rx_done` without `tx_end` → latch the length, go to S_PEND.
    - `tx_end` without `rx_done` → S_IDLE.
    - `tx_end` and `rx_done` together → swap, go to S_IDLE.
  - S_PEND:
    - RX writes are blocked; `rx_valid` is ignored.
    - `rx_done` → `drop_cnt` +1 (saturating).
    - `tx_end` → execute the pending swap, go to S_IDLE. If `rx_done` occurs in the same cycle it is counted as a drop.
- `rx_valid` and `rx_done` in the same cycle: the write lands in the current write bank before any swap.
- `rx_addr` is not range-checked; it wraps naturally within ADDR_W. `rx_data_length` is passed through unchecked.
- Reset mid-frame returns the block to S_IDLE with the default source; RAM data is retained but ignored because `have_rx` is 0.

## Timing
- `tx_rd_data` is registered with 1-cycle latency: the address presented in cycle n gives data in cycle n+1.
- A swap takes effect in the cycle after `rx_done` or `tx_end`. A `tx_start` in that cycle sees the new bank.
- `tx_data_length` and `tx_total_length` are registered.
  - Both update one cycle after a swap or a `src_def` change.
  - Both are frozen from `tx_start` to `tx_end` inclusive.
  - Value = default length when `src_def` is set, else `len_rx[rd_bank]`.
- Reset values:
  - `tx_rd_data` = 0
  - `tx_data_length` = 28, `tx_total_length` = 48 (default parameters)
  - `have_rx` = 0, `drop_cnt` = 0, `rd_bank` = 0
  - state = S_IDLE

## Test plan
- **Reset default:** after reset, `tx_start`, read addresses 0..5 → data 0x48454C4C, 0x4F20414C, 0x494E5820, 0x41583533, 0x30200A0D, then 0; lengths 28/48.
- **Echo:** write 3 words (0x11111111, 0x22222222, 0x33333333) at addresses 0..2, `rx_done` with length 20 → `rd_bank` = 1, `have_rx` = 1, lengths 20/40, reads return the words.
- **Deferred swap:** `tx_start`, then a full RX frame with `rx_done` → state S_PEND, reads still return the old frame. On `tx_end`, the swap occurs next cycle.
- **Drop:** in S_PEND, send another `rx_done` and `rx_valid` writes → `drop_cnt` = 1 and the pending bank is unchanged. Force 300 drops → `drop_cnt` = 255.
- **Mode:** set `mode` = 1 after an echo frame → lengths revert to 28/48 and default data is read. Toggle `mode` mid-TX → no change until `tx_end`.
- **Simultaneous events:** `tx_end` and `rx_done` in the same cycle in S_BUSY → immediate swap to S_IDLE. `tx_start` and `rx_done` in the same cycle in S_IDLE → S_PEND. Reset asserted in S_PEND → S_IDLE with default outputs.
